// File: rtl/issue_ibuffer_pkg.sv
// Shared issue-slot types and constants.
// Payload layout and warp index helpers.
package issue_ibuffer_pkg;

    localparam int ISSUE_RATIO = 4;
    localparam int ISSUE_WIS_W = (ISSUE_RATIO > 1) ? $clog2(ISSUE_RATIO) : 1;

    typedef logic [ISSUE_WIS_W-1:0] wis_t;

    typedef struct packed {
        logic [28:0] uuid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [2:0]  ex_type;
        logic [3:0]  op_type;
        logic [2:0]  op_mod;
        logic        wb;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [31:0] imm;
    } ibuf_data_t;

    localparam int IBUF_DATAW = $bits(ibuf_data_t);

    function automatic int wis_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/issue_ibuffer_warp_fifo.sv
// Per-warp register FIFO for the issue buffer.
// Flush clears occupancy and overrides a same-cycle pop.
module ibuf_warp_fifo
    import issue_ibuffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DATAW = IBUF_DATAW,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [DATAW-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic [DATAW-1:0] head
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush && (count < FULL);
    assign do_pop  = pop && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    // pointers and occupancy; flush wins over everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // payload storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/issue_ibuffer.sv
// Issue-slot instruction buffer: per-warp FIFOs
// with a rotating round-robin head pick.
module issue_ibuffer
    import issue_ibuffer_pkg::*;
#(
    parameter int NUM_WARPS = ISSUE_RATIO,
    parameter int DEPTH     = 2,
    parameter int DATAW     = 128,
    localparam int WIS_W    = wis_width(NUM_WARPS),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       dec_valid,
    input  logic [WIS_W-1:0]           dec_wis,
    input  logic [DATAW-1:0]           dec_data,
    output logic                       dec_ready,
    output logic                       sb_valid,
    output logic [WIS_W-1:0]           sb_wis,
    output logic [DATAW-1:0]           sb_data,
    input  logic                       sb_ready,
    input  logic                       flush_valid,
    input  logic [WIS_W-1:0]           flush_wis,
    output logic [NUM_WARPS*CNT_W-1:0] warp_count,
    output logic [31:0]                perf_hol_skips
);

    localparam logic [WIS_W:0]   NW   = (WIS_W + 1)'(NUM_WARPS);
    localparam logic [WIS_W-1:0] LAST = WIS_W'(NUM_WARPS - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0]     cnt  [NUM_WARPS];
    logic [DATAW-1:0]     head [NUM_WARPS];
    logic [NUM_WARPS-1:0] nonempty;
    logic [NUM_WARPS-1:0] push;
    logic [NUM_WARPS-1:0] pop;
    logic [NUM_WARPS-1:0] flush;
    logic [WIS_W-1:0]     rr;
    logic [WIS_W-1:0]     sel;
    logic [WIS_W-1:0]     sel_next;
    logic [WIS_W:0]       sum;
    logic                 found;
    logic                 others;

    assign dec_ready = (cnt[dec_wis] < FULL)
                     && !(flush_valid && (flush_wis == dec_wis));
    assign sb_valid  = |nonempty;
    assign sb_wis    = sel;
    assign sb_data   = head[sel];
    assign sel_next  = (sel == LAST) ? '0 : sel + 1'b1;

    for (genvar i = 0; i < NUM_WARPS; i++) begin : g_warp
        assign push[i]  = dec_valid && dec_ready
                       && (dec_wis == WIS_W'(i));
        assign pop[i]   = sb_valid && sb_ready
                       && (sel == WIS_W'(i));
        assign flush[i] = flush_valid
                       && (flush_wis == WIS_W'(i));
        assign nonempty[i] = (cnt[i] != '0);
        assign warp_count[i*CNT_W +: CNT_W] = cnt[i];

        ibuf_warp_fifo #(
            .DEPTH (DEPTH),
            .DATAW (DATAW)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[i]),
            .pop     (pop[i]),
            .flush   (flush[i]),
            .data    (dec_data),
            .count   (cnt[i]),
            .head    (head[i])
        );
    end

    // first non-empty warp at or after rr, wrapping
    always_comb begin
        sel   = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            sum = {1'b0, rr} + (WIS_W + 1)'(i);
            if (sum >= NW) sum = sum - NW;
            if (!found && nonempty[sum[WIS_W-1:0]]) begin
                sel   = sum[WIS_W-1:0];
                found = 1'b1;
            end
        end
    end

    // is any warp other than the selected one waiting
    always_comb begin
        others = 1'b0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if ((WIS_W'(i) != sel) && nonempty[i]) others = 1'b1;
        end
    end

    // rotate past the presented warp; count skipped stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr             <= '0;
            perf_hol_skips <= '0;
        end else if (sb_valid) begin
            rr <= sel_next;
            if (!sb_ready && others)
                perf_hol_skips <= perf_hol_skips + 32'd1;
        end
    end

endmodule

// File: tb/tb_issue_ibuffer.sv
// Self-checking bench for issue_ibuffer.
// Queue-based model plus directed literal checks.
module tb_issue_ibuffer;

    localparam int NW = 4;
    localparam int DP = 2;
    localparam int DW = 128;
    localparam int CW = 2;

    logic             clk;
    logic             reset_n;
    logic             dec_valid;
    logic [1:0]       dec_wis;
    logic [DW-1:0]    dec_data;
    logic             dec_ready;
    logic             sb_valid;
    logic [1:0]       sb_wis;
    logic [DW-1:0]    sb_data;
    logic             sb_ready;
    logic             flush_valid;
    logic [1:0]       flush_wis;
    logic [NW*CW-1:0] warp_count;
    logic [31:0]      perf_hol_skips;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q [NW][$];
    int            rr_m;
    int            perf_m;
    int            pop_w[$];
    logic [DW-1:0] pop_d[$];

    issue_ibuffer #(
        .NUM_WARPS (NW),
        .DEPTH     (DP),
        .DATAW     (DW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dec_valid      (dec_valid),
        .dec_wis        (dec_wis),
        .dec_data       (dec_data),
        .dec_ready      (dec_ready),
        .sb_valid       (sb_valid),
        .sb_wis         (sb_wis),
        .sb_data        (sb_data),
        .sb_ready       (sb_ready),
        .flush_valid    (flush_valid),
        .flush_wis      (flush_wis),
        .warp_count     (warp_count),
        .perf_hol_skips (perf_hol_skips)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_sel();
        int w;
        for (int i = 0; i < NW; i++) begin
            w = (rr_m + i) % NW;
            if (q[w].size() > 0) return w;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] log_d(input int k);
        if (k < pop_d.size()) return pop_d[k];
        return 'x;
    endfunction

    function automatic int log_w(input int k);
        if (k < pop_w.size()) return pop_w[k];
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NW; i++) q[i].delete();
        rr_m   = 0;
        perf_m = 0;
        pop_w.delete();
        pop_d.delete();
    endtask

    task automatic compare(input int dw, input bit fv, input int fw);
        int            s;
        bit            rdy;
        logic [NW*CW-1:0] wc;
        s = m_sel();
        chk("sb_valid", DW'(sb_valid), DW'(s >= 0));
        if (s >= 0) begin
            chk("sb_wis", DW'(sb_wis), DW'(s));
            chk("sb_data", sb_data, q[s][0]);
        end
        rdy = (q[dw].size() < DP) && !(fv && fw == dw);
        chk("dec_ready", DW'(dec_ready), DW'(rdy));
        wc = '0;
        for (int i = 0; i < NW; i++) wc[i*CW +: CW] = CW'(q[i].size());
        chk("warp_count", DW'(warp_count), DW'(wc));
        chk("perf_hol_skips", DW'(perf_hol_skips), DW'(perf_m));
    endtask

    task automatic model_step(input bit dv, input int dw,
                              input logic [DW-1:0] dd, input bit sr,
                              input bit fv, input int fw);
        int s;
        bit rdy;
        bit oth;
        s   = m_sel();
        rdy = (q[dw].size() < DP) && !(fv && fw == dw);
        if (s >= 0) begin
            if (sr && !(fv && fw == s)) begin
                pop_w.push_back(s);
                pop_d.push_back(q[s].pop_front());
            end
            if (!sr) begin
                oth = 1'b0;
                for (int w = 0; w < NW; w++)
                    if (w != s && q[w].size() > 0) oth = 1'b1;
                if (oth) perf_m++;
            end
            rr_m = (s + 1) % NW;
        end
        if (fv) q[fw].delete();
        if (dv && rdy) q[dw].push_back(dd);
    endtask

    // srm: 0 = ready low, 1 = ready high, 2 = ready unless warp 0 shown
    task automatic cycle(input bit dv, input int dw, input logic [DW-1:0] dd,
                         input int srm, input bit fv = 1'b0,
                         input int fw = 0);
        int s;
        bit sr;
        s  = m_sel();
        sr = (srm == 2) ? (s != 0) : (srm == 1);
        dec_valid   = dv;
        dec_wis     = 2'(dw);
        dec_data    = dd;
        sb_ready    = sr;
        flush_valid = fv;
        flush_wis   = 2'(fw);
        #1;
        compare(dw, fv, fw);
        @(posedge clk);
        model_step(dv, dw, dd, sr, fv, fw);
        @(negedge clk);
    endtask

    task automatic do_reset();
        dec_valid   = 1'b0;
        dec_wis     = '0;
        dec_data    = '0;
        sb_ready    = 1'b0;
        flush_valid = 1'b0;
        flush_wis   = '0;
        reset_n     = 1'b0;
        #1;
        model_clear();
        chk("rst sb_valid", DW'(sb_valid), '0);
        chk("rst warp_count", DW'(warp_count), '0);
        chk("rst perf", DW'(perf_hol_skips), '0);
        chk("rst dec_ready", DW'(dec_ready), DW'(1));
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        dec_valid   = 1'b0;
        dec_wis     = '0;
        dec_data    = '0;
        sb_ready    = 1'b0;
        flush_valid = 1'b0;
        flush_wis   = '0;
        @(negedge clk);

        // basic path
        do_reset();
        cycle(1, 2, 'hA5, 1);
        chk("basic valid", DW'(sb_valid), DW'(1));
        chk("basic wis", DW'(sb_wis), DW'(2));
        chk("basic data", sb_data, 'hA5);
        chk("basic cnt2", DW'(warp_count[5:4]), DW'(1));
        cycle(0, 0, '0, 1);
        chk("basic cnt2 after pop", DW'(warp_count[5:4]), '0);
        chk("basic pop data", log_d(0), 'hA5);

        // full warp, third push dropped
        do_reset();
        cycle(1, 1, 'h11, 0);
        cycle(1, 1, 'h12, 0);
        cycle(1, 1, 'h13, 0);
        dec_valid = 1'b0;
        dec_wis   = 2'd1;
        #1 chk("full ready w1", DW'(dec_ready), '0);
        dec_wis = 2'd0;
        #1 chk("full ready w0", DW'(dec_ready), DW'(1));
        chk("full cnt1", DW'(warp_count[3:2]), DW'(2));
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);
        chk("full pop0", log_d(0), 'h11);
        chk("full pop1", log_d(1), 'h12);
        chk("full empty", DW'(warp_count), '0);

        // head-of-line rotation
        do_reset();
        cycle(1, 3, 'h31, 0);
        cycle(1, 0, 'h01, 0);
        cycle(1, 0, 'h02, 0);
        chk("hol perf", DW'(perf_hol_skips), DW'(1));
        chk("hol next wis", DW'(sb_wis), DW'(3));
        cycle(0, 0, '0, 2);
        cycle(0, 0, '0, 2);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);
        chk("hol order w0", DW'(log_w(0)), DW'(3));
        chk("hol order d0", log_d(0), 'h31);
        chk("hol order d1", log_d(1), 'h01);
        chk("hol order d2", log_d(2), 'h02);
        chk("hol perf end", DW'(perf_hol_skips), DW'(1));

        // fairness across four full warps
        do_reset();
        for (int w = 0; w < NW; w++)
            for (int k = 0; k < DP; k++)
                cycle(1, w, DW'(w * 16 + k), 0);
        chk("fair all full", DW'(warp_count), 'hAA);
        for (int k = 0; k < 8; k++) cycle(0, 0, '0, 1);
        for (int k = 0; k < 8; k++) begin
            chk("fair order", DW'(log_w(k)), DW'(k % 4));
            chk("fair data", log_d(k), DW'((k % 4) * 16 + k / 4));
        end

        // back-to-back push and pop on one warp
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 1, DW'('h100 + i), 1);
        chk("thru cnt1", DW'(warp_count[3:2]), DW'(1));
        chk("thru head", sb_data, 'h105);
        chk("thru pop4", log_d(4), 'h104);

        // flush while presented and ready
        do_reset();
        cycle(1, 1, 'h41, 0);
        cycle(1, 1, 'h42, 0);
        cycle(1, 0, 'h51, 1, 1'b1, 1);
        chk("flush cnt1", DW'(warp_count[3:2]), '0);
        chk("flush cnt0", DW'(warp_count[1:0]), DW'(1));
        chk("flush no pop", DW'(pop_w.size()), '0);
        chk("flush head", sb_data, 'h51);
        cycle(1, 2, 'h61, 0, 1'b1, 2);
        chk("flush blocks push", DW'(warp_count[5:4]), '0);

        // reset with five entries buffered
        cycle(1, 0, 'h52, 0);
        cycle(1, 1, 'h71, 0);
        cycle(1, 2, 'h72, 0);
        cycle(1, 3, 'h73, 0);
        chk("mid fill", DW'(warp_count), 'h56);
        do_reset();
        cycle(1, 3, 'h81, 0);
        chk("post rst wis", DW'(sb_wis), DW'(3));
        chk("post rst data", sb_data, 'h81);

        // mixed traffic
        for (int i = 0; i < 40; i++)
            cycle(i % 3 != 0, (i * 3) % 4, DW'('h200 + i),
                  (i % 4 == 1) ? 0 : 1, i % 11 == 5, (i * 5) % 4);
        for (int i = 0; i < 12; i++) cycle(0, 0, '0, 1);
        chk("drain empty", DW'(warp_count), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
